// File: rtl/cle_pkg.sv
// Shared CLE definitions: label-memory geometry and requester ids.
package cle_pkg;

  // sram_1024x8 label memory geometry
  localparam int CLE_AW = 10;
  localparam int CLE_DW = 8;

  // Requester ids on the label-memory arbiter
  localparam logic REQ_LAB = 1'b0;  // raster labeling pass
  localparam logic REQ_REL = 1'b1;  // equivalence / relabel pass

  // Width of the lock burst counter (MAX_LOCK is 1..15)
  localparam int LCNT_W = 4;

endpackage

// File: rtl/cle_rr_pick.sv
// Combinational 2-way round-robin picker with lock override.
// When locked only the owner can win; otherwise a lone request wins and a
// tie goes to the requester that was not granted last.
module cle_rr_pick
  import cle_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       locked,
  input  logic       owner,
  output logic [1:0] gnt
);

  // Grant selection; at most one bit of gnt is ever set
  always_comb begin
    gnt = 2'b00;
    if (locked) begin
      gnt[owner] = req[owner];
    end else if (&req) begin
      if (last == REQ_REL) gnt[REQ_LAB] = 1'b1;
      else                 gnt[REQ_REL] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/cle_sram_arb.sv
// Two-requester arbiter for the CLE sram_1024x8 label memory.
//
// Handshake: a requester raises req with we/lock/addr/wdata and holds them
// stable until it sees gnt high. gnt is combinational; the access is taken by
// the SRAM on the rising edge at which gnt is high, so a granted command is
// complete at that edge. Read data comes back one cycle later, qualified by
// rvalid (registered). Writes never produce rvalid.
//
// lock asks to keep the grant for the next access (read-modify-write burst).
// A lock is capped at MAX_LOCK consecutive grants so the other side is not
// starved; after the cap `last` still names the owner, so the other
// requester wins the following tie.
module cle_sram_arb
  import cle_pkg::*;
#(
  parameter int AW       = CLE_AW,
  parameter int DW       = CLE_DW,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen,
  input  logic [DW-1:0] sram_q
);

  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOCK);

  logic              last;
  logic              locked;
  logic              owner;
  logic [LCNT_W-1:0] lcnt;
  logic              rpend0;
  logic              rpend1;

  logic              locked_n;
  logic              owner_n;
  logic [LCNT_W-1:0] lcnt_n;

  logic [1:0]        req_v;
  logic [1:0]        lock_v;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              gid;
  logic              g_lock;

  assign req_v   = {req1, req0};
  assign lock_v  = {lock1, lock0};
  assign any_gnt = |gnt;
  assign gid     = gnt[REQ_REL];

  cle_rr_pick u_pick (
    .req    (req_v),
    .last   (last),
    .locked (locked),
    .owner  (owner),
    .gnt    (gnt)
  );

  assign gnt0 = gnt[REQ_LAB];
  assign gnt1 = gnt[REQ_REL];

  // SRAM pin mux: granted requester drives the pins, otherwise pins idle
  always_comb begin
    sram_a   = '0;
    sram_d   = '0;
    sram_wen = 1'b1;
    g_lock   = 1'b0;
    if (gnt[REQ_REL]) begin
      sram_a   = addr1;
      sram_d   = wdata1;
      sram_wen = ~we1;
      g_lock   = lock1;
    end else if (gnt[REQ_LAB]) begin
      sram_a   = addr0;
      sram_d   = wdata0;
      sram_wen = ~we0;
      g_lock   = lock0;
    end
  end

  // Next lock state: start/extend a burst, cap it, or drop an abandoned lock
  always_comb begin
    locked_n = locked;
    owner_n  = owner;
    lcnt_n   = lcnt;
    if (any_gnt) begin
      if (g_lock) begin
        if (!locked) begin
          locked_n = 1'b1;
          owner_n  = gid;
          lcnt_n   = LCNT_W'(1);
        end else begin
          lcnt_n = lcnt + LCNT_W'(1);
        end
        if (lcnt_n == LCNT_MAX) begin
          locked_n = 1'b0;
          lcnt_n   = '0;
        end
      end else begin
        locked_n = 1'b0;
        lcnt_n   = '0;
      end
    end else if (locked && !req_v[owner] && !lock_v[owner]) begin
      locked_n = 1'b0;
      lcnt_n   = '0;
    end
  end

  // Arbitration and read-pending state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last   <= REQ_REL;
      locked <= 1'b0;
      owner  <= REQ_LAB;
      lcnt   <= '0;
      rpend0 <= 1'b0;
      rpend1 <= 1'b0;
    end else begin
      if (any_gnt) last <= gid;
      rpend0 <= gnt[REQ_LAB] & ~we0;
      rpend1 <= gnt[REQ_REL] & ~we1;
      locked <= locked_n;
      owner  <= owner_n;
      lcnt   <= lcnt_n;
    end
  end

  assign rvalid0 = rpend0;
  assign rvalid1 = rpend1;
  assign rdata0  = sram_q;
  assign rdata1  = sram_q;

endmodule

// File: doc/cle_sram_arb.md
# cle_sram_arb

Two-requester arbiter for the single-port `sram_1024x8` label memory inside `CLE`. Requester 0 is the raster labeling pass, which writes provisional labels. Requester 1 is the equivalence/relabel pass, which does reads and read-modify-write. The block multiplexes both onto the SRAM `A/D/WEN` pins with round-robin fairness and a bounded lock for atomic read-modify-write bursts. It returns read data to the owner one cycle after grant.

## Interface
Parameters:
- `AW`, 10, SRAM address width (1024 words).
- `DW`, 8, data width.
- `MAX_LOCK`, 4, maximum consecutive locked grants per owner; range 1..15.

Ports:
- `clk`  in  1  system clock; SRAM samples on the same rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req0`, `req1`  in  1  access request; hold stable until granted.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `lock0`, `lock1`  in  1  keep the grant for the next access (RMW burst).
- `addr0`, `addr1`  in  AW  word address.
- `wdata0`, `wdata1`  in  DW  write data.
- `gnt0`, `gnt1`  out  1  combinational grant; the access completes at this edge.
- `rvalid0`, `rvalid1`  out  1  registered; read data valid this cycle.
- `rdata0`, `rdata1`  out  DW  `sram_q` routed to both; meaningful only with `rvalid`.
- `sram_a`  out  AW  to SRAM `A`.
- `sram_d`  out  DW  to SRAM `D`.
- `sram_wen`  out  1  to SRAM `WEN`, active-low write.
- `sram_q`  in  DW  from SRAM `Q`.

## Operation
- **State:** `last` (1 bit, last-granted requester), `locked` (1 bit), `owner` (1 bit), `lcnt` (4 bits), `rpend0`/`rpend1`.
- **Reset values:** `last`=1, so requester 0 wins the first tie; `locked`=0; `lcnt`=0; `rpend`=0. Outputs at reset: `rvalid0`=`rvalid1`=0 and `gnt`=0 unless requested. SRAM pins idle.
- **Grant rule, unlocked:**
  - If exactly one `req` is high, grant it.
  - If both are high, grant `~last`.
  - Never assert both grants.
- **Grant rule, locked:** only `owner` may be granted. The other requester waits even when `owner` is idle.
- **SRAM mux:**
  - Granted: `sram_a`/`sram_d` come from the granted requester, and `sram_wen`=~`we`.
  - Idle: `sram_a`=0, `sram_d`=0, `sram_wen`=1.
- **At each edge with a grant `g` for requester `i`:**
  - `last`←`i`.
  - `rpend_i`←~`we_i`; the other `rpend` clears.
  - **Lock update:**
    - `lock_i`=1 and not locked: `locked`←1, `owner`←`i`, `lcnt`←1.
    - `lock_i`=1 and locked: `lcnt`←`lcnt`+1.
    - `lock_i`=0: `locked`←0, `lcnt`←0.
  - If the updated `lcnt` equals `MAX_LOCK`, force `locked`←0 and `lcnt`←0. `last` stays the owner, so the other requester wins the next tie.
- **Edge with no grant:** `rpend` clears. The lock is kept unless `owner`'s `req` is low and `lock` is low, in which case the lock releases.
- **Read return:** `rvalid_i` = `rpend_i` (registered). `rdata_i` = `sram_q` during that cycle.
- **Write return:** writes produce no `rvalid`.

## Timing
- **Read latency:** with `req`+`gnt` in cycle t, `rvalid` and data arrive in cycle t+1.
- **Throughput:** one access per cycle, back-to-back. A read at t followed by a write at t+1 to the same address returns the old data at t+1.
- **Write-then-read:** a write at t followed by a read at t+1 to the same address returns the new data at t+2.
- **Tie:** both requesters requesting continuously alternate 0,1,0,1… from reset.
- **Lock cap:** a lock held continuously yields exactly `MAX_LOCK` consecutive owner grants. The other requester, if pending, is granted on the next cycle.
- **Asynchronous reset mid-read:** `rvalid` drops immediately and `locked` clears. The SRAM pins go idle in the same cycle unless a `req` is high.

## Structure
- **Shared package `cle_pkg`:** `CLE_AW`=10, `CLE_DW`=8, requester-id localparams `REQ_LAB`=0 and `REQ_REL`=1. `CLE` and this block both import them.
- **Sub-module `cle_rr_pick`:** a combinational 2-way round-robin picker (inputs `req[1:0]`, `last`, `locked`, `owner`; output `gnt[1:0]`).
- **Top-level contents:** the lock counter and the read-pending registers stay in the top level.

## Test plan
- **Reset:** assert `reset` with both `req`=0 → `gnt`=0, `rvalid`=0, `sram_wen`=1, `sram_a`=0. Then `req0` write `addr0`=10'h021, `wdata0`=8'h05 → `gnt0`=1 in the same cycle; SRAM mem[0x021]=8'h05 after the edge.
- **Single read:** `req1` read 0x021 at cycle t → `gnt1` at t; `rvalid1`=1 and `rdata1`=8'h05 at t+1 only.
- **Tie:** both `req` held for 6 cycles after reset → grant order 0,1,0,1,0,1, with no cycle where both `gnt` are high.
- **RMW lock:** `req1`+`lock1` read 0x040, then write 0x040 with `lock1`=0, while `req0` is held → grants 1,1,0; `req0` waits 2 cycles.
- **Lock cap** (`MAX_LOCK`=4): `req1`+`lock1` held for 8 cycles with `req0` held → `gnt1` ×4, then `gnt0` ×1, then `gnt1` resumes.
- **Reset mid-read:** `reset` pulse mid-cycle at t+1 after a read grant at t → `rvalid` falls asynchronously. After release, the first tie grants requester 0.
